cdb_complete_arbiter: RTL
=========================

# cdb_complete_arbiter

Consumer end of the FU result/`full_hazard` handshake. Each cycle it picks up to `NUM_CDB` completed FU results (`done=1`), registers them onto the common data bus (CDB) for the PR file, RS wakeup and ROB completion, and returns `full_hazard` to every completed FU it did not pick so that FU holds its result. Priority is round-robin across FUs. A saturating per-FU wait counter flags starvation.

## Interface
Parameters:
- `NUM_FU`, 4: number of FU result inputs.
- `NUM_CDB`, 2: CDB broadcast slots per cycle, 1..`NUM_FU`.
- `PR_W`, 6: physical-register tag width, `$clog2(NUM_PR)`.
- `STARVE_LIMIT`, 15: wait-cycle threshold for `starve_err`. Counter width is `$clog2(STARVE_LIMIT+1)`.

Ports:
- `clock`, in, 1: system clock. One clock.
- `reset`, in, 1: reset is synchronous and active-low. Asserted when 0.
- `fu_result`, in, `NUM_FU` x `FU_RESULT_ENTRY_t`: per-FU `{done, T_idx[PR_W], result[64]}`.
- `cdb_ready`, in, 1: the downstream write port can accept a broadcast this cycle.
- `full_hazard`, out, `NUM_FU`: combinational. 1 tells the FU to hold its current result.
- `cdb_valid`, out, `NUM_CDB`: registered slot-valid.
- `cdb_T_idx`, out, `NUM_CDB` x `PR_W`: registered destination tag.
- `cdb_result`, out, `NUM_CDB` x 64: registered value.
- `starve_err`, out, 1: registered and sticky.

## Operation
- Request: `req[i] = fu_result[i].done`.
- Arbitration (combinational):
  - Scan `i = rr_ptr, rr_ptr+1, …` modulo `NUM_FU`.
  - Grant the first `NUM_CDB` FUs with `req` set.
  - The k-th grant in scan order goes to slot k. Slots above the grant count are invalid.
- `cdb_ready=0`: no grants are issued.
- `full_hazard[i] = req[i] & ~grant[i]`. It is forced to 0 while `reset` is asserted.
- Broadcast register, at each edge:
  - `cdb_valid[k] <= slot k granted`.
  - Granted slots: `cdb_T_idx[k]` and `cdb_result[k]` load the granted FU's fields.
  - Ungranted slots: tag and result hold their previous values. Consumers must qualify on `cdb_valid`.
- Pointer update:
  - If at least one grant: `rr_ptr <= (last granted index + 1) mod NUM_FU`.
  - Otherwise `rr_ptr` holds.
- Wait counter per FU:
  - Increments, saturating at `STARVE_LIMIT`, when `req & ~grant`.
  - Clears when granted or when `req=0`.
- `starve_err`:
  - Sets when any counter equals `STARVE_LIMIT`.
  - Clears only on reset.
- Arithmetic:
  - Modulo wrap uses an explicit compare against `NUM_FU-1`. No power-of-two assumption.
  - Tags and results pass through unmodified.

## Timing
- Reset values: `cdb_valid=0`, `cdb_T_idx=0`, `cdb_result=0`, `rr_ptr=0`, all wait counters 0, `starve_err=0`.
- During reset, `full_hazard=0` and no grants are issued.
- Latency: an FU granted in cycle N appears on the CDB in cycle N+1. The CDB stays valid for exactly one cycle per grant.
- An FU hazarded in cycle N must present the same `T_idx`/`result` with `done=1` in cycle N+1. The arbiter does not buffer it.
- Requests ≤ `NUM_CDB`: all are granted, `full_hazard` is all zero, and the pointer still advances.
- All `NUM_FU` requesting: any FU waits at most `ceil(NUM_FU/NUM_CDB)-1` cycles while `cdb_ready=1`.
- `rr_ptr = NUM_FU-1`: the scan wraps to index 0 in the same cycle.
- `cdb_ready` low: every requester is hazarded, `rr_ptr` holds, counters run, and `cdb_valid` is 0 next cycle.
- Reset asserted mid-stream: next-edge outputs take reset values and in-flight CDB data is dropped.

## Structure
- Shared package (`sys_defs`): `FU_RESULT_ENTRY_t`, a new `CDB_ENTRY_t {valid, T_idx, result}`, and `NUM_CDB`, alongside the existing `NUM_FU` and `NUM_PR`.
- One sub-module, `cdb_rr_pick`: combinational rotate-priority picker. Inputs are `req` and `rr_ptr`; outputs are the `grant` vector, per-slot FU index and valid, and last-granted index. The parent holds all flops.

## Test plan
Defaults apply: `NUM_FU=4`, `NUM_CDB=2`.
- Reset: `reset=0` for 2 cycles with all `done=1` → `full_hazard=0000`, `cdb_valid=00`, `starve_err=0`. Then release with `done=0001`, `T_idx=5`, `result=0xAB` → next cycle `cdb_valid[0]=1`, `cdb_T_idx[0]=5`, `cdb_result[0]=0xAB`.
- Contention: `done=1111`, `rr_ptr=0`.
  - Cycle 1 → grant FU0/FU1, `full_hazard=1100`, `rr_ptr→2`.
  - Cycle 2 → grant FU2/FU3, slots in order 2 then 3.
- Wrap: `rr_ptr=3`, `done=1001` → slot0=FU3, slot1=FU0, `rr_ptr→1`.
- Back-pressure: `cdb_ready=0` for 3 cycles with `done=0110` → `full_hazard=0110`, `cdb_valid=00`, `rr_ptr` unchanged, and the held FU values broadcast unchanged one cycle after `cdb_ready=1`.
- Starvation: `cdb_ready=0` for 15 cycles with FU2 `done` → `starve_err=1` after cycle 15, still 1 after traffic resumes, and 0 only after reset.

Source files
------------

// File: rtl/sys_defs.sv
// Shared core-wide sizes and inter-stage bundles.
// Holds the FU-result and CDB broadcast entry types.
package sys_defs;

  localparam int NUM_FU  = 4;
  localparam int NUM_PR  = 64;
  localparam int NUM_CDB = 2;
  localparam int PR_W    = $clog2(NUM_PR);

  typedef struct packed {
    logic            done;
    logic [PR_W-1:0] T_idx;
    logic [63:0]     result;
  } FU_RESULT_ENTRY_t;

  typedef struct packed {
    logic            valid;
    logic [PR_W-1:0] T_idx;
    logic [63:0]     result;
  } CDB_ENTRY_t;

endpackage

// File: rtl/cdb_rr_pick.sv
// Rotating-priority picker: first NUM_CDB requesters
// from rr_ptr onward, k-th grant mapped to slot k.
module cdb_rr_pick #(
  parameter int NUM_FU  = 4,
  parameter int NUM_CDB = 2,
  localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int CW = $clog2(NUM_CDB + 1)
) (
  input  logic [NUM_FU-1:0]           req,
  input  logic [IW-1:0]               rr_ptr,
  output logic [NUM_FU-1:0]           grant,
  output logic [NUM_CDB-1:0][IW-1:0]  slot_idx,
  output logic [NUM_CDB-1:0]          slot_vld,
  output logic [IW-1:0]               last_idx,
  output logic                        any_grant
);

  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;

  always_comb begin
    grant    = '0;
    slot_idx = '0;
    slot_vld = '0;
    last_idx = rr_ptr;
    idx      = rr_ptr;
    cnt      = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      if (req[idx] && (cnt < CW'(NUM_CDB))) begin
        grant[idx]    = 1'b1;
        slot_idx[cnt] = idx;
        slot_vld[cnt] = 1'b1;
        last_idx      = idx;
        cnt           = cnt + 1'b1;
      end
      // explicit wrap, NUM_FU need not be a power of two
      idx = (idx == IW'(NUM_FU - 1)) ? '0 : idx + 1'b1;
    end
    any_grant = |grant;
  end

endmodule

// File: rtl/cdb_complete_arbiter.sv
// Picks up to NUM_CDB completed FU results per cycle onto
// the CDB; hazards the rest and flags starvation.
module cdb_complete_arbiter
  import sys_defs::*;
#(
  parameter int NUM_FU       = sys_defs::NUM_FU,
  parameter int NUM_CDB      = sys_defs::NUM_CDB,
  parameter int PR_W         = sys_defs::PR_W,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                           clock,
  input  logic                           reset,
  input  FU_RESULT_ENTRY_t [NUM_FU-1:0]  fu_result,
  input  logic                           cdb_ready,
  output logic [NUM_FU-1:0]              full_hazard,
  output logic [NUM_CDB-1:0]             cdb_valid,
  output logic [NUM_CDB-1:0][PR_W-1:0]   cdb_T_idx,
  output logic [NUM_CDB-1:0][63:0]       cdb_result,
  output logic                           starve_err
);

  localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [NUM_FU-1:0]          req;
  logic [NUM_FU-1:0]          req_m;
  logic [NUM_FU-1:0]          grant;
  logic [NUM_CDB-1:0][IW-1:0] slot_idx;
  logic [NUM_CDB-1:0]         slot_vld;
  logic [IW-1:0]              last_idx;
  logic                       any_grant;
  logic [IW-1:0]              rr_ptr;
  logic [NUM_FU-1:0][SW-1:0]  wait_cnt;
  logic [NUM_FU-1:0][SW-1:0]  wait_nxt;
  logic                       starve_hit;
  CDB_ENTRY_t [NUM_CDB-1:0]   cdb_q;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++)
      req[i] = fu_result[i].done;
  end

  assign req_m = (reset && cdb_ready) ? req : '0;

  cdb_rr_pick #(
    .NUM_FU  (NUM_FU),
    .NUM_CDB (NUM_CDB)
  ) u_pick (
    .req       (req_m),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .slot_idx  (slot_idx),
    .slot_vld  (slot_vld),
    .last_idx  (last_idx),
    .any_grant (any_grant)
  );

  assign full_hazard = reset ? (req & ~grant) : '0;

  always_comb begin
    starve_hit = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      wait_nxt[i] = '0;
      if (req[i] && !grant[i])
        wait_nxt[i] = (wait_cnt[i] == SW'(STARVE_LIMIT)) ?
                      wait_cnt[i] : wait_cnt[i] + 1'b1;
      if (wait_nxt[i] == SW'(STARVE_LIMIT))
        starve_hit = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cdb_q      <= '0;
      rr_ptr     <= '0;
      wait_cnt   <= '0;
      starve_err <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_q[k].valid <= slot_vld[k];
        if (slot_vld[k]) begin
          cdb_q[k].T_idx  <= fu_result[slot_idx[k]].T_idx;
          cdb_q[k].result <= fu_result[slot_idx[k]].result;
        end
      end
      if (any_grant)
        rr_ptr <= (last_idx == IW'(NUM_FU - 1)) ?
                  '0 : last_idx + 1'b1;
      wait_cnt   <= wait_nxt;
      starve_err <= starve_err | starve_hit;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_valid[k]  = cdb_q[k].valid;
      cdb_T_idx[k]  = PR_W'(cdb_q[k].T_idx);
      cdb_result[k] = cdb_q[k].result;
    end
  end

endmodule
